// File: rtl/pipelined_barrel_shifter_pkg.sv
// pipelined_barrel_shifter_pkg: shift-mode encodings shared by the shifter top and its stages.
// The optional BARREL_SHIFTER_OVF_EN build adds a signed-overflow flag carried through the stages.
package pipelined_barrel_shifter_pkg;
  typedef enum logic [1:0] {
    SHIFT_LSL = 2'b00,
    SHIFT_LSR = 2'b01,
    SHIFT_ASR = 2'b10,
    SHIFT_ROR = 2'b11
  } shift_op_e;
endpackage

// File: rtl/pipelined_barrel_shifter_stage.sv
// barrel_shift_stage: one elastic stage that shifts by STEP when its shamt bit is set.
// With BARREL_SHIFTER_OVF_EN the stage also accumulates the LSL signed-overflow flag.
module barrel_shift_stage
  import pipelined_barrel_shifter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic [WIDTH-1:0]           data_i,
  input  logic [$clog2(WIDTH)-1:0]   shamt_i,
  input  logic [1:0]                 op_i,
  input  logic                       carry_i,
`ifdef BARREL_SHIFTER_OVF_EN
  input  logic                       ovf_i,
  output logic                       ovf_o,
`endif
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(WIDTH)-1:0]   shamt_o,
  output logic [1:0]                 op_o,
  output logic                       carry_o
);
  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int K = $clog2(STEP);
  typedef struct packed {
    logic [WIDTH-1:0]   data;
    logic [SHAMT_W-1:0] shamt;
    logic [1:0]         op;
    logic               carry;
`ifdef BARREL_SHIFTER_OVF_EN
    logic               ovf;
`endif
  } payload_t;
  payload_t pl_d, pl_q;
  logic valid_q, act;
  logic [WIDTH-1:0] asr, shifted;
  assign asr = $signed(data_i) >>> STEP;
  always_comb begin
    act = shamt_i[K];
    shifted = op_i == SHIFT_LSL ? data_i << STEP :
              op_i == SHIFT_LSR ? data_i >> STEP :
              op_i == SHIFT_ASR ? asr : {data_i[STEP-1:0], data_i[WIDTH-1:STEP]};
    pl_d.data = act ? shifted : data_i;
    pl_d.shamt = shamt_i;
    pl_d.op = op_i;
    pl_d.carry = act ? (op_i == SHIFT_LSL ? data_i[WIDTH-STEP] : data_i[STEP-1]) : carry_i;
`ifdef BARREL_SHIFTER_OVF_EN
    // bits leaving plus the bit landing in the sign position must all agree
    pl_d.ovf = ovf_i | (act && op_i == SHIFT_LSL &&
               !(&data_i[WIDTH-1:WIDTH-1-STEP]) && |data_i[WIDTH-1:WIDTH-1-STEP]);
`endif
  end
  assign ready_o = !valid_q || ready_i;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pl_q <= '0;
    end else begin
      if (flush) valid_q <= 1'b0;
      else if (ready_o) valid_q <= valid_i;
      if (ready_o && valid_i) pl_q <= pl_d;
    end
  end
  assign valid_o = valid_q;
  assign data_o = pl_q.data;
  assign shamt_o = pl_q.shamt;
  assign op_o = pl_q.op;
  assign carry_o = pl_q.carry;
`ifdef BARREL_SHIFTER_OVF_EN
  assign ovf_o = pl_q.ovf;
`endif
endmodule

// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter: elastic log2(WIDTH)-stage LSL/LSR/ASR/ROR shifter with carry and zero flags.
// Define BARREL_SHIFTER_OVF_EN to add the out_ovf signed-overflow output.
module pipelined_barrel_shifter
  import pipelined_barrel_shifter_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_carry,
`ifdef BARREL_SHIFTER_OVF_EN
  output logic               out_ovf,
`endif
  output logic               out_zero
);
  logic [SHAMT_W:0]              valid_c, ready_c, carry_c;
  logic [SHAMT_W:0][WIDTH-1:0]   data_c;
  logic [SHAMT_W:0][SHAMT_W-1:0] shamt_c;
  logic [SHAMT_W:0][1:0]         op_c;
  logic                          unused_tail;
`ifdef BARREL_SHIFTER_OVF_EN
  logic [SHAMT_W:0]              ovf_c;
  assign ovf_c[0] = 1'b0;
  assign out_ovf = ovf_c[SHAMT_W];
`endif
  assign valid_c[0] = in_valid;
  assign data_c[0] = in_data;
  assign shamt_c[0] = in_shamt;
  assign op_c[0] = in_op;
  assign carry_c[0] = 1'b0;
  assign ready_c[SHAMT_W] = out_ready;
  assign in_ready = ready_c[0];
  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    barrel_shift_stage #(.WIDTH(WIDTH), .STEP(1 << k)) u_stage (
      .clk    (clk),
      .rst_n  (rst_n),
      .flush  (flush),
      .valid_i(valid_c[k]),
      .ready_o(ready_c[k]),
      .data_i (data_c[k]),
      .shamt_i(shamt_c[k]),
      .op_i   (op_c[k]),
      .carry_i(carry_c[k]),
`ifdef BARREL_SHIFTER_OVF_EN
      .ovf_i  (ovf_c[k]),
      .ovf_o  (ovf_c[k+1]),
`endif
      .valid_o(valid_c[k+1]),
      .ready_i(ready_c[k+1]),
      .data_o (data_c[k+1]),
      .shamt_o(shamt_c[k+1]),
      .op_o   (op_c[k+1]),
      .carry_o(carry_c[k+1])
    );
  end
  assign out_valid = valid_c[SHAMT_W];
  assign out_data = data_c[SHAMT_W];
  assign out_carry = carry_c[SHAMT_W];
  // gated by valid so the flag reads 0 out of reset even though the data register is 0
  assign out_zero = out_valid && ~|out_data;
  assign unused_tail = ^{shamt_c[SHAMT_W], op_c[SHAMT_W]};
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// tb_pipelined_barrel_shifter: directed vector table plus backpressure, flush and reset sequences.
module tb_pipelined_barrel_shifter;
  typedef struct {
    logic [1:0] op;
    logic [2:0] shamt;
    logic [7:0] data;
    logic [7:0] exp_data;
    logic       exp_carry;
    logic       exp_zero;
    logic       exp_ovf;
  } vec_t;
  logic clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, out_carry, out_zero;
  logic [7:0] in_data = 0, out_data;
  logic [2:0] in_shamt = 0;
  logic [1:0] in_op = 0;
`ifdef BARREL_SHIFTER_OVF_EN
  logic out_ovf;
`endif
  int checks = 0, failures = 0;
  vec_t vecs[16];
  always #5 clk = ~clk;
  pipelined_barrel_shifter #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_shamt(in_shamt), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_carry(out_carry),
`ifdef BARREL_SHIFTER_OVF_EN
    .out_ovf(out_ovf),
`endif
    .out_zero(out_zero)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask
  task automatic drive(input int i);
    in_op = vecs[i].op;
    in_shamt = vecs[i].shamt;
    in_data = vecs[i].data;
  endtask
  task automatic run_vec(input int i);
    int lat;
    @(negedge clk);
    drive(i);
    in_valid = 1;
    out_ready = 1;
    #1 chk($sformatf("v%0d_in_ready", i), in_ready, 1);
    @(negedge clk);
    in_valid = 0;
    lat = 1;
    while (!out_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    chk($sformatf("v%0d_latency", i), lat, 3);
    chk($sformatf("v%0d_data", i), out_data, vecs[i].exp_data);
    chk($sformatf("v%0d_carry", i), out_carry, vecs[i].exp_carry);
    chk($sformatf("v%0d_zero", i), out_zero, vecs[i].exp_zero);
`ifdef BARREL_SHIFTER_OVF_EN
    chk($sformatf("v%0d_ovf", i), out_ovf, vecs[i].exp_ovf);
`endif
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    int acc, got, gaps, stale;
    bit take, started;
    vecs[0]  = '{2'b00, 3'd1, 8'h81, 8'h02, 1'b1, 1'b0, 1'b1};
    vecs[1]  = '{2'b10, 3'd3, 8'h80, 8'hF0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{2'b01, 3'd4, 8'h0F, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{2'b11, 3'd1, 8'h01, 8'h80, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{2'b00, 3'd0, 8'hA5, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{2'b01, 3'd0, 8'hA5, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{2'b10, 3'd0, 8'hA5, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{2'b11, 3'd0, 8'hA5, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{2'b00, 3'd7, 8'h03, 8'h80, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{2'b10, 3'd7, 8'h80, 8'hFF, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{2'b11, 3'd3, 8'h96, 8'hD2, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{2'b01, 3'd7, 8'h80, 8'h01, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{2'b00, 3'd1, 8'h40, 8'h80, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{2'b00, 3'd1, 8'h20, 8'h40, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{2'b00, 3'd1, 8'h80, 8'h00, 1'b1, 1'b1, 1'b1};
    vecs[15] = '{2'b10, 3'd2, 8'h40, 8'h10, 1'b0, 1'b0, 1'b0};
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_carry", out_carry, 0);
    chk("rst_out_zero", out_zero, 0);
`ifdef BARREL_SHIFTER_OVF_EN
    chk("rst_out_ovf", out_ovf, 0);
`endif
    rst_n = 1;
    #1 chk("rst_in_ready", in_ready, 1);
    for (int i = 0; i < 16; i++) run_vec(i);
    // backpressure: five back-to-back beats against a stalled consumer
    @(negedge clk);
    out_ready = 0;
    acc = 0;
    drive(0);
    in_valid = 1;
    for (int c = 0; c < 6; c++) begin
      #1 take = in_valid && in_ready;
      @(negedge clk);
      if (take) begin
        acc++;
        if (acc < 5) drive(acc); else in_valid = 0;
      end
    end
    chk("bp_accepted_while_stalled", acc, 3);
    #1 chk("bp_in_ready_low", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_stable_data", out_data, vecs[0].exp_data);
    chk("bp_stable_carry", out_carry, vecs[0].exp_carry);
    out_ready = 1;
    got = 0;
    gaps = 0;
    started = 0;
    for (int c = 0; c < 20 && got < 5; c++) begin
      #1 take = in_valid && in_ready;
      if (out_valid) begin
        chk($sformatf("bp_out%0d_data", got), out_data, vecs[got].exp_data);
        got++;
        started = 1;
      end else if (started) gaps++;
      @(negedge clk);
      if (take) begin
        acc++;
        if (acc < 5) drive(acc); else in_valid = 0;
      end
    end
    chk("bp_total_accepted", acc, 5);
    chk("bp_total_out", got, 5);
    chk("bp_gaps", gaps, 0);
    // flush three in-flight beats plus one offered in the flush cycle
    out_ready = 0;
    acc = 0;
    drive(8);
    in_valid = 1;
    for (int c = 0; c < 3; c++) begin
      #1 take = in_valid && in_ready;
      @(negedge clk);
      if (take) begin
        acc++;
        drive(8 + acc);
      end
    end
    chk("fl_in_flight", acc, 3);
    flush = 1;
    out_ready = 1;
    @(negedge clk);
    flush = 0;
    in_valid = 0;
    #1 chk("fl_out_valid_cleared", out_valid, 0);
    chk("fl_in_ready", in_ready, 1);
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    chk("fl_no_stale", stale, 0);
    // asynchronous reset while the pipe is streaming
    drive(9);
    in_valid = 1;
    @(negedge clk) drive(10);
    @(negedge clk) drive(11);
    @(negedge clk) drive(12);
    @(negedge clk) in_valid = 0;
    chk("rs_streaming", out_valid, 1);
    #2 rst_n = 0;
    #1 chk("rs_out_valid_async", out_valid, 0);
    chk("rs_out_data_async", out_data, 0);
    chk("rs_out_carry_async", out_carry, 0);
    @(negedge clk) rst_n = 1;
    #1 chk("rs_in_ready", in_ready, 1);
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    chk("rs_no_stale", stale, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
Parametrised, pipelined barrel shifter for the datapath.
- Shifts a WIDTH-bit operand by a variable amount, 0..WIDTH-1.
- Four modes: logical left, logical right, arithmetic right, rotate right.
- Produces carry (last bit shifted out) and zero flags.
- Elastic log2(WIDTH)-stage pipeline with valid/ready handshakes on both sides. Sits between the register-read stage and ALU writeback.

Parameters:
- WIDTH, 8, operand width; power of two, at least 4.
- SHAMT_W, $clog2(WIDTH), shift-amount width and pipeline depth; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- flush  in  1  synchronous pipeline clear.
- in_valid  in  1  input beat valid.
- in_ready  out  1  pipeline can accept the input beat.
- in_data  in  WIDTH  operand.
- in_shamt  in  SHAMT_W  shift amount.
- in_op  in  2  mode: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  WIDTH  shifted result.
- out_carry  out  1  last bit shifted/rotated out; 0 when shamt=0.
- out_zero  out  1  out_data == 0.

Behaviour:
- Reset (rst_n low, asynchronous): all stage valids=0, all stage registers=0.
  - out_valid=0, out_data=0, out_carry=0, out_zero=0.
  - in_ready=1 once rst_n is high.
- Transfer occurs when valid && ready on an edge.
- Stage k (k=0..SHAMT_W-1) registers {valid, data, shamt, op, carry}.
  - When shamt[k]=1, it shifts by 2^k:
    - LSL zero-fills at the LSB.
    - LSR zero-fills at the MSB.
    - ASR fills with the original bit WIDTH-1.
    - ROR wraps.
  - Carry on an active stage:
    - LSL: data[WIDTH-2^k].
    - LSR/ASR: data[2^k-1].
    - ROR: the new data[WIDTH-1].
  - Inactive stage: data and carry pass unchanged.
  - Carry enters stage 0 as 0.
- Latency: exactly SHAMT_W cycles from input acceptance to out_valid, with no stall.
- Throughput: one beat per cycle.
- Advance rule:
  - Stage k loads when stage k is empty, or stage k+1 takes its current beat in the same cycle.
  - The last stage drains when out_ready=1.
  - in_ready = stage0 empty or stage0 advancing (combinational through ready chain).
- Backpressure: with out_ready held low, the pipeline fills SHAMT_W beats, then in_ready=0. There is no beat loss or duplication.
- out_data, out_carry and out_zero are stable while out_valid && !out_ready.
- out_zero is computed from the final stage register, not from in_data.
- flush=1: all valids cleared at the next edge; flush beats accepted in that cycle are dropped. flush has priority over in_valid.
- Shift amounts:
  - shamt=0 passes data through with carry=0.
  - shamt=WIDTH-1 LSL leaves only the original bit 0 at the MSB.
  - ASR of a negative operand by WIDTH-1 gives all ones.
- in_op and in_shamt are sampled only on acceptance; mid-flight changes have no effect.

Optional Feature:
BARREL_SHIFTER_OVF_EN
- Defined:
  - Adds output out_ovf (1 bit), pipelined with the data.
  - For LSL, out_ovf=1 if any bit shifted out, or any bit passed through the original sign position, differs from the final out_data[WIDTH-1] (signed overflow).
  - 0 for the other modes. Reset value 0.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Shared package:
  - op encodings: SHIFT_LSL=2'b00, SHIFT_LSR=2'b01, SHIFT_ASR=2'b10, SHIFT_ROR=2'b11.
  - A stage-payload struct typedef {data, shamt, op, carry}, parametrised by width via the module.
- Sub-module barrel_shift_stage:
  - Parameters WIDTH, STEP (=2^k).
  - Combinational shift and carry for one stage, plus its valid/payload register and advance logic.
  - Instantiated SHAMT_W times by a generate loop.

Test Plan:
- WIDTH=8, LSL in_data=0x81 shamt=1 -> after 3 cycles out_data=0x02, carry=1, zero=0.
- ASR 0x80 shamt=3 -> 0xF0, carry=0. LSR 0x0F shamt=4 -> 0x00, carry=1, zero=1.
- ROR 0x01 shamt=1 -> 0x80, carry=1. Any op with shamt=0 on 0xA5 -> 0xA5, carry=0.
- Backpressure: out_ready=0, offer 5 back-to-back beats.
  - Required: in_ready falls after 3 accepted.
  - Then raise out_ready: all 5 results emerge in order, with no gaps once streaming.
- flush while 3 beats are in flight, then rst_n pulsed low mid-stream:
  - Required: out_valid=0 the next cycle after flush, and immediately on reset assert.
  - Required: no stale beat emerges afterwards.
- With BARREL_SHIFTER_OVF_EN defined:
  - LSL 0x40 shamt=1 -> 0x80, ovf=1.
  - LSL 0x20 shamt=1 -> 0x40, ovf=0.
